arb4_rr_ctrl: RTL

ARB4_RR_CTRL -- requirements
Module: arb4_rr_ctrl

---
 rtl/arb4_pkg.sv | 27 ++
 rtl/dec2to4_l.sv | 14 +
 rtl/arb4_rr_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/arb4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds the FSM state type, requester count and hold default.
package arb4_pkg;

  localparam int NUM_REQ      = 4;
  localparam int HOLD_MAX_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Nearest active-low request after 'last' wins; 'last' itself is tried last.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] last,
    input logic [3:0] req_l
  );
    logic [1:0] idx;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + 2'(k);
      if (!req_l[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/dec2to4_l.sv
// 2-to-4 decoder with active-low enable and active-low outputs.
// Drives the grant lines from registered owner/state only.
module dec2to4_l (
  input  logic       en_l,
  input  logic [1:0] sel,
  output logic [3:0] y_l
);

  always_comb begin
    y_l = 4'b1111;
    if (!en_l) y_l[sel] = 1'b0;
  end

endmodule

// File: rtl/arb4_rr_ctrl.sv
// 4-requester round-robin arbiter, IDLE/GRANT/GAP FSM.
// Define ARB_TIMEOUT_EN to cap ownership at HOLD_MAX grant cycles.
module arb4_rr_ctrl
  import arb4_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic [3:0] REQ_L,
  output logic [3:0] GNT_L,
  output logic [1:0] OWNER,
  output logic       BUSY
);

  arb_state_t state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [1:0] win;
  logic       any_req;
  logic       hold_done;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX out of range 2..255");
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      hold_q <= 8'd0;
    end else if (state_q != GRANT) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_q + 8'd1;
    end
  end

  assign hold_done = (hold_q == 8'(HOLD_MAX - 1));
`else
  assign hold_done = 1'b0;
`endif

  assign any_req = ~&REQ_L;
  assign win     = rr_pick(last_q, REQ_L);

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= IDLE;
      owner_q <= 2'b00;
      last_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          state_d = GRANT;
          owner_d = win;
          last_d  = win;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (REQ_L[owner_q] || hold_done) state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  dec2to4_l u_dec (
    .en_l (state_q != GRANT),
    .sel  (owner_q),
    .y_l  (GNT_L)
  );

  assign OWNER = owner_q;
  assign BUSY  = (state_q == GRANT);

endmodule
